// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package ifq_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst} entries with flush; head is
// the raw slot at the read pointer.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  ifq_entry_t       push_data,
    input  logic             pop,
    output ifq_entry_t       head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             full;

    always_comb begin
        empty  = (count == '0);
        full   = (count == FULL_CNT);
        do_pop = pop && !empty;
        head   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem[wr_ptr] <= push_data;
    end

    // Slot reservation upstream makes this unreachable in a correct system.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
                                    !(push && full && !do_pop));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order response buffering,
// redirect flush with stale-response dropping. Optional IFQ_BYPASS_EN macro.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready
);

    localparam int unsigned CNT_W = clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [PC_W-1:0]  redirect_base;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight;
    logic             fifo_empty;
    logic             accept;
    logic             live_resp;
    logic             bypass;
    logic             push;
    logic             pop;
    ifq_entry_t       push_data;
    ifq_entry_t       head;

    always_comb begin
        redirect_base = {redirect_pc[PC_W-1:2], 2'b00};
        inflight      = {1'b0, fifo_count} + {1'b0, outstanding};
        imem_req      = !rst && !redirect && (inflight < DEPTH_V);
        imem_addr     = fetch_pc;
        accept        = imem_req && imem_gnt;
        live_resp     = imem_rvalid && (drop_cnt == '0) && !redirect;
        push_data     = '{pc: resp_pc, inst: imem_rdata};
        pop           = !fifo_empty && inst_ready && !redirect;
`ifdef IFQ_BYPASS_EN
        bypass     = live_resp && fifo_empty && inst_ready;
        inst_valid = !fifo_empty || bypass;
        if (bypass) begin
            inst    = imem_rdata;
            inst_pc = resp_pc;
        end else if (!fifo_empty) begin
            inst    = head.inst;
            inst_pc = head.pc;
        end else begin
            inst    = '0;
            inst_pc = '0;
        end
`else
        bypass     = 1'b0;
        inst_valid = !fifo_empty;
        inst       = fifo_empty ? '0 : head.inst;
        inst_pc    = fifo_empty ? '0 : head.pc;
`endif
        push = live_resp && !bypass;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rvalid);
            if (redirect) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                // outstanding counts stale responses too, so this equals
                // drop_cnt + live outstanding - rvalid.
                drop_cnt <= outstanding - CNT_W'(imem_rvalid);
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_INC;
                if (live_resp) resp_pc <= resp_pc + PC_INC;
                if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: in-order memory model with configurable
// latency, expected instruction stream queue, and a decoupled monitor.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    req_t pend[$];
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int acc_cnt = 0;

    logic        n_rst = 1'b1, n_redirect = 1'b0, n_gnt = 1'b0, n_ready = 1'b0;
    logic [31:0] n_redirect_pc = '0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a + 32'h2402_0005;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic expect_item(input logic [31:0] pc, input logic [31:0] data);
        exp_t e;
        e.pc = pc;
        e.inst = data;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs at negedge, settle, capture outputs, record accepts.
    task automatic step();
        req_t r;
        @(negedge clk);
        cyc++;
        rst = n_rst;
        redirect = n_redirect;
        redirect_pc = n_redirect_pc;
        imem_gnt = n_gnt;
        inst_ready = n_ready;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_fn(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = '0;
        end
        #1;
        s_req = imem_req;
        s_addr = imem_addr;
        s_valid = inst_valid;
        s_pc = inst_pc;
        s_inst = inst;
        if (imem_req && imem_gnt) begin
            r.addr = imem_addr;
            r.due = cyc + lat;
            pend.push_back(r);
            acc_cnt++;
        end
    endtask

    task automatic do_reset();
        pend.delete();
        n_rst = 1'b1;
        n_redirect = 1'b0;
        n_gnt = 1'b0;
        n_ready = 1'b0;
        step();
        step();
        chkb("rst_req", s_req, 1'b0);
        chk("rst_addr", s_addr, 32'h0);
        chkb("rst_valid", s_valid, 1'b0);
        chk("rst_inst", s_inst, 32'h0);
        chk("rst_pc", s_pc, 32'h0);
        acc_cnt = 0;
        n_rst = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        n_gnt = 1'b0;
        n_ready = 1'b1;
        n_redirect = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (exp_q.size() == 0 && pend.size() == 0 && !s_valid) done = 1'b1;
        end
        chkb({name, "_drain_done"}, done, 1'b1);
        chk({name, "_left_expected"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    // Monitor: every consumed instruction is compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && inst_valid && inst_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst actual pc=%h inst=%h required none", inst_pc, inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_inst_pc", inst_pc, e.pc);
                    chk("mon_inst", inst, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Streaming with 1-cycle memory and CPU always ready.
        do_reset();
        lat = 1;
        n_gnt = 1'b1;
        n_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_item(32'(4 * i), 32'h2402_0005 + 32'(4 * i));
        step();
        chkb("t1_first_req", s_req, 1'b1);
        chk("t1_first_addr", s_addr, 32'h0);
        step();
        chkb("t1_valid_in_rvalid_cycle", s_valid, BYP);
        step();
        chkb("t1_valid_next_cycle", s_valid, 1'b1);
        repeat (5) step();
        chk("t1_accepts", 32'(acc_cnt), 32'd8);
        drain("t1");

        // Backpressure: DEPTH=4 slots reserved, then one pop frees one slot.
        do_reset();
        lat = 1;
        n_gnt = 1'b1;
        n_ready = 1'b0;
        expect_item(32'h0, 32'h2402_0005);
        repeat (8) step();
        chk("t2_accepts_full", 32'(acc_cnt), 32'd4);
        chkb("t2_req_low_full", s_req, 1'b0);
        chkb("t2_valid_held", s_valid, 1'b1);
        chk("t2_head_pc_held", s_pc, 32'h0);
        n_ready = 1'b1;
        step();
        chkb("t2_req_low_pop_cycle", s_req, 1'b0);
        n_ready = 1'b0;
        step();
        chkb("t2_req_after_pop", s_req, 1'b1);
        chk("t2_addr_after_pop", s_addr, 32'h10);
        chk("t2_new_head_pc", s_pc, 32'h4);
        step();
        chk("t2_accepts_after", 32'(acc_cnt), 32'd5);
        chkb("t2_req_low_again", s_req, 1'b0);
        expect_item(32'h4, 32'h2402_0009);
        expect_item(32'h8, 32'h2402_000D);
        expect_item(32'hC, 32'h2402_0011);
        expect_item(32'h10, 32'h2402_0015);
        drain("t2");

        // 3-cycle memory, redirect to unaligned PC with two requests in flight.
        do_reset();
        lat = 3;
        n_gnt = 1'b1;
        n_ready = 1'b1;
        step();
        step();
        n_redirect = 1'b1;
        n_redirect_pc = 32'h0000_0103;
        step();
        chkb("t3_req_low_on_redirect", s_req, 1'b0);
        n_redirect = 1'b0;
        step();
        chkb("t3_req_after_redirect", s_req, 1'b1);
        chk("t3_addr_after_redirect", s_addr, 32'h0000_0100);
        chkb("t3_valid_low_after_redirect", s_valid, 1'b0);
        step();
        n_gnt = 1'b0;
        expect_item(32'h0000_0100, 32'h2402_0105);
        expect_item(32'h0000_0104, 32'h2402_0109);
        drain("t3");

        // Redirect coincident with rvalid and a pop attempt.
        do_reset();
        lat = 2;
        n_gnt = 1'b1;
        n_ready = 1'b0;
        step();
        step();
        step();
        n_redirect = 1'b1;
        n_redirect_pc = 32'h0000_0200;
        n_ready = 1'b1;
        step();
        chkb("t4_valid_at_redirect", s_valid, 1'b1);
        chk("t4_head_at_redirect", s_pc, 32'h0);
        chkb("t4_req_low_redirect", s_req, 1'b0);
        n_redirect = 1'b0;
        step();
        chkb("t4_empty_after_redirect", s_valid, 1'b0);
        chkb("t4_req_after_redirect", s_req, 1'b1);
        chk("t4_addr_after_redirect", s_addr, 32'h0000_0200);
        step();
        n_gnt = 1'b0;
        expect_item(32'h0000_0200, 32'h2402_0205);
        expect_item(32'h0000_0204, 32'h2402_0209);
        drain("t4");

        // fetch_pc wrap from the top of the address space.
        do_reset();
        lat = 1;
        n_gnt = 1'b1;
        n_ready = 1'b1;
        n_redirect = 1'b1;
        n_redirect_pc = 32'hFFFF_FFFE;
        step();
        n_redirect = 1'b0;
        step();
        chk("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        step();
        chkb("t5_req_wrap", s_req, 1'b1);
        chk("t5_addr_wrap", s_addr, 32'h0000_0000);
        n_gnt = 1'b0;
        expect_item(32'hFFFF_FFFC, 32'h2402_0001);
        expect_item(32'h0000_0000, 32'h2402_0005);
        drain("t5");

        // Second redirect while stale responses are still pending.
        do_reset();
        lat = 3;
        n_gnt = 1'b1;
        n_ready = 1'b1;
        step();
        step();
        n_redirect = 1'b1;
        n_redirect_pc = 32'h0000_0300;
        step();
        n_redirect = 1'b0;
        step();
        chk("t6_addr_first_redirect", s_addr, 32'h0000_0300);
        n_redirect = 1'b1;
        n_redirect_pc = 32'h0000_0400;
        step();
        n_redirect = 1'b0;
        step();
        chk("t6_addr_second_redirect", s_addr, 32'h0000_0400);
        step();
        n_gnt = 1'b0;
        expect_item(32'h0000_0400, 32'h2402_0405);
        expect_item(32'h0000_0404, 32'h2402_0409);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
